muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU. It is fed by the forwarded EX operands (FRSE/FRTE) and the decoded op of `instrE`. It produces `hi`/`lo` for MFHI/MFLO, which are muxed into ALUOutE ahead of ex_mem. `busy` is consumed by the hazard unit to stall any MULT/DIV/MFHI/MFLO/MTHI/MTLO that reaches decode while an operation is in flight.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv.sv | 182 ++++++++++++++++++
 tb/tb_muldiv.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand, MTHI/MTLO and result bundle of the EX-stage multiply/divide unit.
// The master side (pipeline control) launches operations and reads HI/LO back.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wdata,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operations run on magnitudes; signs are reapplied when the final step writes HI/LO.
module muldiv (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        neg_lo_q, neg_lo_d;   // product or quotient negated at the end
  logic        neg_hi_q, neg_hi_d;   // remainder negated at the end
  logic        div0_q, div0_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic [31:0] opb_q, opb_d;         // multiplicand or divisor magnitude
  logic [32:0] acc_q, acc_d;         // product upper half or partial remainder
  logic [31:0] work_q, work_d;       // multiplier bits or dividend/quotient bits
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Launch-time operand conditioning
  logic        op_signed;
  logic [31:0] a_mag, b_mag;

  assign op_signed = ~bus.op[0];
  assign a_mag = (op_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_mag = (op_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  // One radix-2 step of each algorithm
  logic [32:0] mul_sum;
  logic [32:0] mul_acc_nxt;
  logic [31:0] mul_work_nxt;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [32:0] div_acc_nxt;
  logic [31:0] div_work_nxt;
  logic        is_div;

  assign is_div = op_q[1];

  always_comb begin
    mul_sum      = {1'b0, acc_q[31:0]} + {1'b0, (work_q[0] ? opb_q : 32'd0)};
    mul_acc_nxt  = {1'b0, mul_sum[32:1]};
    mul_work_nxt = {mul_sum[0], work_q[31:1]};

    div_shift = {acc_q[31:0], work_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    if (div_diff[33]) begin
      div_acc_nxt  = div_shift;
      div_work_nxt = {work_q[30:0], 1'b0};
    end else begin
      div_acc_nxt  = div_diff[32:0];
      div_work_nxt = {work_q[30:0], 1'b1};
    end
  end

  // Sign-corrected results, only consumed on the final step
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    prod_mag = {mul_acc_nxt[31:0], mul_work_nxt};
    prod_fix = neg_lo_q ? (~prod_mag + 64'd1) : prod_mag;
    quo_fix  = neg_lo_q ? (~div_work_nxt + 32'd1) : div_work_nxt;
    rem_fix  = neg_hi_q ? (~div_acc_nxt[31:0] + 32'd1) : div_acc_nxt[31:0];
    if (!is_div) begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end else if (div0_q) begin
      res_hi = orig_a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    orig_a_d = orig_a_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    work_d   = work_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StRun;
          busy_d   = 1'b1;
          cnt_d    = 5'd31;
          op_d     = bus.op;
          neg_lo_d = op_signed & (bus.a[31] ^ bus.b[31]);
          neg_hi_d = op_signed & bus.a[31];
          div0_d   = (bus.b == 32'd0);
          orig_a_d = bus.a;
          acc_d    = 33'd0;
          unique case (bus.op)
            OpMult, OpMultu: begin
              opb_d  = a_mag;
              work_d = b_mag;
            end
            OpDiv, OpDivu: begin
              opb_d  = b_mag;
              work_d = a_mag;
            end
            default: ;
          endcase
        end else begin
          if (bus.we_hi) hi_d = bus.wdata;
          if (bus.we_lo) lo_d = bus.wdata;
        end
      end
      StRun: begin
        acc_d  = is_div ? div_acc_nxt : mul_acc_nxt;
        work_d = is_div ? div_work_nxt : mul_work_nxt;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      op_q     <= 2'b00;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      orig_a_q <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 33'd0;
      work_q   <= 32'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      orig_a_q <= orig_a_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Bench for muldiv: directed corner cases plus random operations, each checked against
// a plain-arithmetic HI/LO model.
module tb_muldiv;

  logic clk;
  logic rst;
  muldiv_if bus ();

  muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  logic [31:0] hi_m, lo_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} as the architecture defines them
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        return p;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b11) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit glitch, input bit we_at_start);
    logic [63:0] exp;
    int cycles;
    bit held;
    exp = ref_op(op, a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.we_hi = we_at_start;
    bus.we_lo = we_at_start;
    bus.wdata = $urandom;
    @(posedge clk);
    #1;
    clear_inputs();
    chk("busy_on", 64'(bus.busy), 64'd1);
    cycles = 0;
    held = 1'b1;
    while (bus.busy && cycles < 40) begin
      if (bus.hi !== hi_m || bus.lo !== lo_m) held = 1'b0;
      if (glitch) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.we_hi = 1'b1;
        bus.we_lo = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    clear_inputs();
    chk("busy_len", 64'(cycles), 64'd32);
    chk("hold", 64'(held), 64'd1);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    chk("hi", 64'(bus.hi), 64'(hi_m));
    chk("lo", 64'(bus.lo), 64'(lo_m));
    if (glitch) begin
      @(posedge clk);
      #1;
      chk("no_second_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic mt(input bit whi, input bit wlo, input logic [31:0] data);
    @(negedge clk);
    bus.we_hi = whi;
    bus.we_lo = wlo;
    bus.wdata = data;
    #1;
    chk("no_bypass", {bus.hi, bus.lo}, {hi_m, lo_m});
    @(posedge clk);
    #1;
    clear_inputs();
    if (whi) hi_m = data;
    if (wlo) lo_m = data;
    chk("mt_hi", 64'(bus.hi), 64'(hi_m));
    chk("mt_lo", 64'(bus.lo), 64'(lo_m));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.wdata = 32'd0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0);
    chk("mult_dir", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_dir", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_dir", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_dir", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("divu_zero", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    chk("div_zero", {bus.hi, bus.lo}, 64'hFFFF_FFF0_FFFF_FFFF);

    do_op(2'b01, 32'd2, 32'd3, 1'b1, 1'b0);
    chk("gate_res", {bus.hi, bus.lo}, 64'h0000_0000_0000_0006);
    mt(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("mtlo_dir", {bus.hi, bus.lo}, 64'h0000_0000_DEAD_BEEF);
    mt(1'b1, 1'b1, 32'h0BAD_F00D);

    // Start in the same cycle as MTHI/MTLO drops the writes
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'h7654_3210;
    bus.b     = 32'd13;
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    do_op(2'b00, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("post_rst_mult", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
